// File: rtl/scatter_sequencer_pkg.sv
// Shared types for the charge-scatterer sequencer: particle/step formats,
// grid geometry and the pass state enumeration.
package scatter_sequencer_pkg;

    localparam int GRID_ADDRWIDTH = 8;
    localparam int CWIDTH         = 16;

    typedef logic [2:0] step_t;

    typedef struct packed {
        logic [15:0] pos;
        logic [15:0] weight;
    } particle_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCATTER = 3'd1,
        DRAIN   = 3'd2,
        READOUT = 3'd3,
        FLUSH   = 3'd4
    } seq_state_t;

    // Lane address for a request pair: lane 0 gets 2r, lane 1 gets 2r+1 (wrapping).
    function automatic logic [GRID_ADDRWIDTH-1:0] lane_addr(
        input logic [GRID_ADDRWIDTH-1:0] pair_idx,
        input logic                      lane
    );
        return (pair_idx << 1) | GRID_ADDRWIDTH'(lane);
    endfunction

endpackage

// File: rtl/scatter_sequencer_latency_pipe.sv
// Valid+payload shift register of fixed depth; used to line grid read
// requests up with the scatterer's read data.
module latency_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
    assign o_busy  = |r_valid;

endmodule

// File: rtl/scatter_sequencer.sv
// Sequences one deposition pass: stream particles, wait for the scatterer to
// drain, sweep the grid through the read port and forward charges to the sink.
module scatter_sequencer
    import scatter_sequencer_pkg::*;
#(
    parameter int NUM_ADDRS     = 256,
    parameter int READ_LATENCY  = 2,
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  step_t                               step_in,
    output logic                                busy,
    output logic                                done,
    output logic                                err_timeout,
    input  logic                                p_valid,
    output logic                                p_ready,
    input  logic                                p_tlast,
    input  particle_t [1:0]                     p_data,
    output step_t                               sc_step,
    output logic                                sc_valid_scatter,
    output logic                                sc_tlast,
    output particle_t [1:0]                     sc_particle,
    input  logic                                sc_tlast_out,
    output logic                                sc_valid_req,
    output logic [1:0][GRID_ADDRWIDTH-1:0]      sc_grid_addr,
    input  logic [1:0][3:0][CWIDTH-1:0]         sc_charge,
    output logic                                g_valid,
    output logic [1:0][GRID_ADDRWIDTH-1:0]      g_addr,
    output logic [1:0][3:0][CWIDTH-1:0]         g_charge,
    output logic [15:0]                         beat_count,
    output seq_state_t                          dbg_state
);

    localparam int AW = $clog2(NUM_ADDRS/2) + 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    seq_state_t                     r_state;
    logic [AW-1:0]                  r_req;
    logic [TW-1:0]                  r_to;
    step_t                          r_step;
    logic                           r_done;
    logic                           r_err;
    logic                           r_sc_valid;
    logic                           r_sc_tlast;
    particle_t [1:0]                r_particle;
    logic [15:0]                    r_beats;
    logic                           r_g_valid;
    logic [1:0][GRID_ADDRWIDTH-1:0] r_g_addr;
    logic [1:0][3:0][CWIDTH-1:0]    r_g_charge;

    logic                           w_req;
    logic [1:0][GRID_ADDRWIDTH-1:0] w_addr;
    logic                           w_tap_valid;
    logic [1:0][GRID_ADDRWIDTH-1:0] w_tap_addr;
    logic                           w_pipe_busy;

    // Particle handshake: a beat transfers on a rising edge where p_valid and
    // p_ready are both high; p_ready is high for every SCATTER cycle.
    assign p_ready = (r_state == SCATTER);
    assign w_req   = (r_state == READOUT);

    always_comb begin
        w_addr = '0;
        if (w_req) begin
            w_addr[0] = lane_addr(GRID_ADDRWIDTH'(r_req), 1'b0);
            w_addr[1] = lane_addr(GRID_ADDRWIDTH'(r_req), 1'b1);
        end
    end

    latency_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (2*GRID_ADDRWIDTH)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .i_valid (w_req),
        .i_data  (w_addr),
        .o_valid (w_tap_valid),
        .o_data  (w_tap_addr),
        .o_busy  (w_pipe_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_to       <= '0;
            r_step     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sc_valid <= 1'b0;
            r_sc_tlast <= 1'b0;
            r_particle <= '0;
            r_beats    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_sc_valid <= 1'b0;
            r_sc_tlast <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_step  <= step_in;
                        r_beats <= '0;
                        r_err   <= 1'b0;
                        r_state <= SCATTER;
                    end
                end
                SCATTER: begin
                    if (p_valid) begin
                        r_particle <= p_data;
                        r_sc_valid <= 1'b1;
                        r_sc_tlast <= p_tlast;
                        if (r_beats != 16'hFFFF) r_beats <= r_beats + 16'd1;
                        if (p_tlast) begin
                            r_to    <= '0;
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A drain indication on the last allowed cycle still wins over the abort.
                    if (sc_tlast_out) begin
                        r_req   <= '0;
                        r_state <= READOUT;
                    end else if (r_to == TW'(DRAIN_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                READOUT: begin
                    if (r_req == AW'(NUM_ADDRS/2 - 1)) r_state <= FLUSH;
                    else                                r_req   <= r_req + 1'b1;
                end
                FLUSH: begin
                    // Pipe empty means the last tap has already been captured into g_*.
                    if (!w_pipe_busy) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g_valid  <= 1'b0;
            r_g_addr   <= '0;
            r_g_charge <= '0;
        end else begin
            r_g_valid <= w_tap_valid;
            if (w_tap_valid) begin
                r_g_addr   <= w_tap_addr;
                r_g_charge <= sc_charge;
            end
        end
    end

    assign busy             = (r_state != IDLE);
    assign done             = r_done;
    assign err_timeout      = r_err;
    assign sc_step          = r_step;
    assign sc_valid_scatter = r_sc_valid;
    assign sc_tlast         = r_sc_tlast;
    assign sc_particle      = r_particle;
    assign sc_valid_req     = w_req;
    assign sc_grid_addr     = w_addr;
    assign g_valid          = r_g_valid;
    assign g_addr           = r_g_addr;
    assign g_charge         = r_g_charge;
    assign beat_count       = r_beats;
    assign dbg_state        = r_state;

endmodule
